// File: rtl/mips_cpu_div_pkg.sv
// Shared types and helpers for the mips_cpu radix-2 restoring divider.
package mips_cpu_div_pkg;

    localparam int DIV_WIDTH = 32;
    // Magnitude helper works at a fixed wide width.
    // Negation then truncation yields the right low bits for any WIDTH <= MAG_W.
    localparam int MAG_W = 64;

    typedef enum logic [1:0] {IDLE, CALC, FIXUP} div_state_t;

    function automatic logic [MAG_W-1:0] twos_mag(input logic [MAG_W-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

endpackage

// File: rtl/mips_cpu_div_step.sv
// One combinational restoring-division iteration: shift {rem,quo} left, trial subtract.
module mips_cpu_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor_mag,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] sh;
    logic [WIDTH:0] diff;
    logic           ge;

    assign sh       = {rem, quo[WIDTH-1]};
    assign ge       = (sh >= {1'b0, divisor_mag});
    assign diff     = sh - {1'b0, divisor_mag};
    // A kept difference is always below divisor_mag, so it fits in WIDTH bits.
    assign rem_next = WIDTH'(ge ? diff : sh);
    assign quo_next = {quo[WIDTH-2:0], ge};

endmodule

// File: rtl/mips_cpu_div_unit.sv
// Multi-cycle DIV/DIVU unit feeding HI/LO. Define MIPS_DIV_EARLY_EXIT_EN to let
// divide-by-zero and |dividend| < |divisor| skip the iteration phase.
module mips_cpu_div_unit
    import mips_cpu_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    div_state_t       state;
    logic [WIDTH-1:0] rem, quo, dsr_mag;
    logic [WIDTH-1:0] rem_nx, quo_nx;
    logic [CNT_W-1:0] cnt;
    logic             q_neg, r_neg, dbz_r;

    logic             dvd_neg, dsr_neg, dbz_in;
    logic [WIDTH-1:0] dvd_mag, dsr_in_mag;

    assign dvd_neg    = is_signed & dividend[WIDTH-1];
    assign dsr_neg    = is_signed & divisor[WIDTH-1];
    assign dbz_in     = (divisor == '0);
    assign dvd_mag    = WIDTH'(twos_mag(MAG_W'(dividend), dvd_neg));
    assign dsr_in_mag = WIDTH'(twos_mag(MAG_W'(divisor), dsr_neg));

    mips_cpu_div_step #(.WIDTH(WIDTH)) u_step (
        .rem         (rem),
        .quo         (quo),
        .divisor_mag (dsr_mag),
        .rem_next    (rem_nx),
        .quo_next    (quo_nx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            rem         <= '0;
            quo         <= '0;
            dsr_mag     <= '0;
            cnt         <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            dbz_r       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        // Divide-by-zero runs the raw dividend through with no sign
                        // fixup, so DIV and DIVU give identical results.
                        dbz_r   <= dbz_in;
                        q_neg   <= ~dbz_in & (dvd_neg ^ dsr_neg);
                        r_neg   <= ~dbz_in & dvd_neg;
                        dsr_mag <= dsr_in_mag;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        rem     <= '0;
                        quo     <= dbz_in ? dividend : dvd_mag;
                        state   <= CALC;
`ifdef MIPS_DIV_EARLY_EXIT_EN
                        if (dbz_in) begin
                            quo   <= '1;
                            rem   <= dividend;
                            state <= FIXUP;
                        end else if (dvd_mag < dsr_in_mag) begin
                            quo   <= '0;
                            rem   <= dvd_mag;
                            state <= FIXUP;
                        end
`endif
                    end
                end
                CALC: begin
                    rem <= rem_nx;
                    quo <= quo_nx;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1))
                        state <= FIXUP;
                end
                FIXUP: begin
                    quotient    <= WIDTH'(twos_mag(MAG_W'(quo), q_neg));
                    remainder   <= WIDTH'(twos_mag(MAG_W'(rem), r_neg));
                    div_by_zero <= dbz_r;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mips_cpu_div_unit.md
Name: mips_cpu_div_unit

Overview:
Multi-cycle radix-2 restoring divider that executes DIV/DIVU for the mips_cpu_bus datapath. It consumes rs/rt operands from register-file read, and its results go to the HI/LO registers. The CPU control FSM holds off MFHI/MFLO while busy is high. One division is in flight at a time; operands are captured at start.

Parameters:
WIDTH, 32, operand/result width in bits (only 32 is used by the CPU; must be >= 2).
CNT_W, $clog2(WIDTH)+1, iteration counter width.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  request a division; sampled only when busy==0
is_signed  input  1  1=DIV (two's complement), 0=DIVU; captured with start
dividend  input  WIDTH  rs operand; captured with start
divisor  input  WIDTH  rt operand; captured with start
busy  output  1  high from the edge after start is accepted until done
done  output  1  one-cycle pulse; quotient/remainder valid
quotient  output  WIDTH  to LO
remainder  output  WIDTH  to HI
div_by_zero  output  1  captured divisor was 0; valid with done, held

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0; counter and working registers cleared. Reset mid-operation aborts the division with no done pulse.
- States: IDLE, CALC, FIXUP.
- IDLE + start=1 at edge E0:
  - Capture magnitudes |dividend| and |divisor|. Magnitude is only taken when is_signed=1.
  - Capture the sign flags q_neg = sign(dividend) XOR sign(divisor) and r_neg = sign(dividend).
  - Capture div_by_zero = (divisor==0).
  - Set counter=0, busy=1, next state CALC.
- CALC: one restoring step per edge.
  - Shift {rem,quo} left by 1.
  - Trial subtract: rem - divisor_mag, computed WIDTH+1 bits wide.
  - If the result is non-negative, keep the difference and set quo LSB=1.
  - After WIDTH steps (edges E1..E32), go to FIXUP.
- FIXUP, edge E33:
  - quotient = q_neg ? -quo : quo.
  - remainder = r_neg ? -rem : rem.
  - done=1 for exactly this one cycle; busy=0; state=IDLE.
- Latency: start sampled at edge E0, so done is high in the cycle after edge E0+WIDTH+1 (33 cycles for WIDTH=32).
- quotient, remainder and div_by_zero hold their values until the next FIXUP or reset. They do not change during CALC.
- start while busy=1 is ignored and has no side effect.
- start during the done cycle is accepted, because the state is already IDLE.
- Inputs may change freely after capture.
- Divide by zero (either signedness):
  - The natural restoring result is used: quotient=all ones, remainder=dividend.
  - Sign fixup is bypassed, so the result is identical for DIV and DIVU.
  - div_by_zero=1.
- Signed overflow 0x80000000 / 0xFFFFFFFF: magnitude 0x80000000/1 gives quotient=0x80000000, remainder=0. No exception.
- Result signs follow MIPS: the quotient truncates toward zero; the remainder takes the sign of the dividend.

Optional Feature:
- Macro: MIPS_DIV_EARLY_EXIT_EN.
- Defined: on acceptance, if divisor==0 or |dividend| < |divisor| (after magnitude conversion), CALC is skipped and the next state is FIXUP.
  - The CALC registers are preloaded with quo=0 and rem=dividend magnitude. For divisor==0, quo=all ones and rem=dividend.
  - done then appears in the cycle after E0+1.
  - All results are bit-identical to the full path.
- Undefined: fixed WIDTH+1-cycle latency for every operation.

Decomposition:
- Package mips_cpu_div_pkg:
  - div_state_t enum {IDLE, CALC, FIXUP};
  - DIV_WIDTH=32;
  - a function for the two's-complement magnitude.
- Natural sub-module: mips_cpu_div_step. It is purely combinational: one shift/trial-subtract iteration, with inputs rem, quo, divisor_mag and outputs rem_next, quo_next. It is instantiated once in CALC.
- FSM, counter and sign fixup stay in mips_cpu_div_unit.

Test Plan:
- DIVU 15/5, start one cycle -> done pulse exactly 33 cycles later (macro off), quotient=0x3, remainder=0x0, div_by_zero=0, busy high for 33 cycles.
- DIVU 0xFFFFFFFF/0x10 -> quotient=0x0FFFFFFF, remainder=0xF. DIV -7/2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF. DIV 7/-2 -> quotient=0xFFFFFFFD, remainder=0x1.
- DIV 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0x0. Divisor 0 with dividend 0x1234 (DIV and DIVU) -> quotient=0xFFFFFFFF, remainder=0x1234, div_by_zero=1.
- Change operands and pulse start at cycle 10 of a busy DIVU 100/7 -> first op unaffected (quotient=14, remainder=2), second start ignored. Start asserted in the done cycle -> new op accepted.
- Assert reset at cycle 15 of an op -> all outputs 0 immediately (async), no done pulse. A new DIVU 9/3 after release -> quotient=3, remainder=0.
- With MIPS_DIV_EARLY_EXIT_EN: DIVU 3/10 -> done 2 cycles after start, quotient=0, remainder=3. Divisor 0 -> 2-cycle done, same values as above. DIVU 15/5 -> still 33 cycles.
